iir_preemph: RTL

// - Transmit-side pre-emphasis filter; the inverse-path counterpart of the receive deemphasis IIR.
// - Boosts high-frequency audio before FM modulation.
// - Pops fixed-point samples from an input FIFO and computes one first-order IIR output per sample:
//   y[n] = DEQ(B0*x[n]) + DEQ(B1*x[n-1]) + DEQ(A1*y[n-1])
// - One shared multiplier, one product per cycle. Pushes y[n] to an output FIFO.
// - Sits between the audio source FIFO and the modulator input FIFO.

---
 rtl/iir_preemph_if.sv | 29 ++
 rtl/iir_preemph.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/iir_preemph_if.sv
//------------------------------------------------------------------------------
// Module  : iir_preemph_if
// Brief   : FIFO-side handshake bundle for the pre-emphasis IIR filter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface iir_preemph_if #(
    parameter int DATA_WIDTH = 32
);
    logic                         x_in_rd_en;
    logic                         x_in_empty;
    logic signed [DATA_WIDTH-1:0] x_in;
    logic signed [DATA_WIDTH-1:0] y_out;
    logic                         y_out_wr_en;
    logic                         y_out_full;

    // master = filter side, slave = surrounding FIFOs
    modport master (
        output x_in_rd_en, y_out, y_out_wr_en,
        input  x_in_empty, x_in, y_out_full
    );
    modport slave (
        input  x_in_rd_en, y_out, y_out_wr_en,
        output x_in_empty, x_in, y_out_full
    );
endinterface

`default_nettype wire

// File: rtl/iir_preemph.sv
//------------------------------------------------------------------------------
// Module  : iir_preemph
// Brief   : First-order fixed-point pre-emphasis IIR, one shared multiplier.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module iir_preemph #(
    parameter int                          DATA_WIDTH = 32,
    parameter int                          QUANT_BITS = 10,
    parameter logic signed [DATA_WIDTH-1:0] B0        = 32'h00000B40,
    parameter logic signed [DATA_WIDTH-1:0] B1        = 32'hFFFFF8A8,
    parameter logic signed [DATA_WIDTH-1:0] A1        = 32'h00000000
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    input  wire logic     clear,
    iir_preemph_if.master bus
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic signed [PW-1:0] c_RND_BIAS =
        {{(PW-QUANT_BITS){1'b0}}, {QUANT_BITS{1'b1}}};

    typedef enum logic [2:0] {
        S_READ  = 3'd0,
        S_MAC0  = 3'd1,
        S_MAC1  = 3'd2,
        S_MAC2  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic signed [DATA_WIDTH-1:0] x0_q, x1_q, y1_q, acc_q, y_out_q;
    logic signed [DATA_WIDTH-1:0] w_coef, w_data, w_deq, w_acc_sum;
    logic signed [PW-1:0]         w_prod, w_rnd, w_shift;
    logic                         w_pop, w_push;

    // Operand select for the single shared multiplier
    always_comb begin
        w_coef = B0;
        w_data = x0_q;
        case (state_q)
            S_MAC1: begin
                w_coef = B1;
                w_data = x1_q;
            end
            S_MAC2: begin
                w_coef = A1;
                w_data = y1_q;
            end
            default: ;
        endcase
    end

    assign w_prod  = $signed({{DATA_WIDTH{w_coef[DATA_WIDTH-1]}}, w_coef}) *
                     $signed({{DATA_WIDTH{w_data[DATA_WIDTH-1]}}, w_data});
    // Biasing negative products before the arithmetic shift rounds toward zero
    assign w_rnd     = w_prod + (w_prod[PW-1] ? c_RND_BIAS : '0);
    assign w_shift   = w_rnd >>> QUANT_BITS;
    assign w_deq     = w_shift[DATA_WIDTH-1:0];
    assign w_acc_sum = acc_q + w_deq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_READ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        w_pop   = 1'b0;
        w_push  = 1'b0;
        case (state_q)
            S_READ: begin
                if (!bus.x_in_empty) begin
                    w_pop   = 1'b1;
                    state_d = S_MAC0;
                end
            end
            S_MAC0:  state_d = S_MAC1;
            S_MAC1:  state_d = S_MAC2;
            S_MAC2:  state_d = S_WRITE;
            S_WRITE: begin
                if (!bus.y_out_full) begin
                    w_push  = 1'b1;
                    state_d = S_READ;
                end
            end
            default: state_d = S_READ;
        endcase
    end

    // Strobes are forced low while reset is held, whatever the FIFO flags say
    assign bus.x_in_rd_en  = w_pop & rst_n;
    assign bus.y_out_wr_en = w_push & rst_n;
    assign bus.y_out       = y_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            acc_q   <= '0;
            y_out_q <= '0;
        end else begin
            case (state_q)
                S_READ: begin
                    if (w_pop) begin
                        x0_q  <= bus.x_in;
                        acc_q <= '0;
                    end
                end
                S_MAC0: acc_q <= w_deq;
                S_MAC1: acc_q <= w_acc_sum;
                S_MAC2: begin
                    acc_q   <= w_acc_sum;
                    y_out_q <= w_acc_sum;
                end
                S_WRITE: begin
                    if (w_push) begin
                        x1_q <= x0_q;
                        y1_q <= y_out_q;
                    end
                end
                default: ;
            endcase
            // Placed last so a clear on the push cycle overrides the history update
            if (clear) begin
                x1_q <= '0;
                y1_q <= '0;
            end
        end
    end

endmodule

`default_nettype wire
